// File: rtl/coax_pkg.sv
// coax_pkg: command codes, FSM encoding and status/word bit positions shared by the SPI burst controller
package coax_pkg;

    localparam logic [3:0] CMD_STATUS   = 4'h1;
    localparam logic [3:0] CMD_RX_RESET = 4'h2;
    localparam logic [3:0] CMD_RX_BURST = 4'h5;

    // Status byte returned by the STATUS command
    localparam int STAT_ACTIVE_BIT = 7;
    localparam int STAT_ERROR_BIT  = 6;
    localparam int STAT_EMPTY_BIT  = 5;

    // Flag positions inside the 16-bit captured RX word
    localparam int WORD_ERROR_BIT = 15;
    localparam int WORD_EMPTY_BIT = 14;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_STATUS,
        ST_RESET_PULSE,
        ST_RX_COUNT,
        ST_RX_SAMPLE,
        ST_RX_HIGH,
        ST_RX_LOW_WAIT,
        ST_RX_NEXT_WAIT,
        ST_DONE
    } state_t;

    function automatic logic [7:0] status_byte(input logic active, input logic error, input logic empty);
        logic [7:0] b;
        b = '0;
        b[STAT_ACTIVE_BIT] = active;
        b[STAT_ERROR_BIT]  = error;
        b[STAT_EMPTY_BIT]  = empty;
        return b;
    endfunction

    // A zero or oversized burst length request means "as many as allowed"
    function automatic logic [7:0] clamp_burst(input logic [7:0] n, input logic [7:0] max_burst);
        return (n == 8'd0 || n > max_burst) ? max_burst : n;
    endfunction

endpackage

// File: rtl/spi_burst_control.sv
// spi_burst_control: decodes SPI slave command bytes and streams RX FIFO words back as byte pairs
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   spi_cs                   chip select (high = deselected, aborts any command)
//   spi_rx_data/strobe       received SPI byte and its one-cycle valid pulse
//   spi_tx_data/strobe       next byte to shift out and its one-cycle load pulse
//   rx_reset                 one-cycle receiver reset pulse
//   rx_active/error/empty    receiver status
//   rx_data                  head word of the RX FIFO
//   rx_read_strobe           one-cycle dequeue pulse for the head word
module spi_burst_control
    import coax_pkg::*;
#(
    parameter int RX_DATA_WIDTH = 10,
    parameter int MAX_BURST     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spi_cs,
    input  logic [7:0]               spi_rx_data,
    input  logic                     spi_rx_strobe,
    output logic [7:0]               spi_tx_data,
    output logic                     spi_tx_strobe,
    output logic                     rx_reset,
    input  logic                     rx_active,
    input  logic                     rx_error,
    input  logic                     rx_empty,
    input  logic [RX_DATA_WIDTH-1:0] rx_data,
    output logic                     rx_read_strobe
);

    if (RX_DATA_WIDTH < 9 || RX_DATA_WIDTH > 14 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
        $error("spi_burst_control: RX_DATA_WIDTH must be 9..14 and MAX_BURST 1..255");
    end

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_stb_q, tx_stb_d;
    logic        rx_rst_q, rx_rst_d;
    logic        rd_stb_q, rd_stb_d;
    logic        word_stop;

    // A captured error or empty flag ends the burst after this word's low byte
    assign word_stop = word_q[WORD_ERROR_BIT] | word_q[WORD_EMPTY_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_stb_q  <= 1'b0;
            rx_rst_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_stb_q  <= tx_stb_d;
            rx_rst_q  <= rx_rst_d;
            rd_stb_q  <= rd_stb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_stb_d  = 1'b0;
        rx_rst_d  = 1'b0;
        rd_stb_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (spi_rx_strobe) begin
                    state_d = spi_rx_data[3:0] == CMD_STATUS   ? ST_STATUS :
                              spi_rx_data[3:0] == CMD_RX_RESET ? ST_RESET_PULSE :
                              spi_rx_data[3:0] == CMD_RX_BURST ? ST_RX_COUNT : ST_IDLE;
                end
            end
            ST_STATUS: begin
                tx_stb_d  = 1'b1;
                tx_data_d = status_byte(rx_active, rx_error, rx_empty);
                state_d   = ST_DONE;
            end
            ST_RESET_PULSE: begin
                rx_rst_d = 1'b1;
                state_d  = ST_DONE;
            end
            ST_RX_COUNT: begin
                if (spi_rx_strobe) begin
                    cnt_d   = clamp_burst(spi_rx_data, MAX_B);
                    state_d = ST_RX_SAMPLE;
                end
            end
            ST_RX_SAMPLE: begin
                word_d  = {rx_error, rx_empty, 14'(rx_data)};
                state_d = ST_RX_HIGH;
            end
            ST_RX_HIGH: begin
                tx_stb_d  = 1'b1;
                tx_data_d = word_q[15:8];
                state_d   = ST_RX_LOW_WAIT;
            end
            ST_RX_LOW_WAIT: begin
                if (spi_rx_strobe) begin
                    tx_stb_d  = 1'b1;
                    tx_data_d = word_q[7:0];
                    // Error wins over dequeue; an empty word is never dequeued
                    rx_rst_d  = word_q[WORD_ERROR_BIT];
                    rd_stb_d  = ~word_q[WORD_ERROR_BIT] & ~word_q[WORD_EMPTY_BIT];
                    cnt_d     = cnt_q - 8'd1;
                    state_d   = (cnt_q == 8'd1 || word_stop) ? ST_DONE : ST_RX_NEXT_WAIT;
                end
            end
            ST_RX_NEXT_WAIT: begin
                if (spi_rx_strobe) state_d = ST_RX_SAMPLE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        // Deselect overrides the transition but not the outputs computed above
        if (spi_cs) state_d = ST_IDLE;
    end

    assign spi_tx_data    = tx_data_q;
    assign spi_tx_strobe  = tx_stb_q;
    assign rx_reset       = rx_rst_q;
    assign rx_read_strobe = rd_stb_q;

endmodule

// File: doc/spi_burst_control.md
SPI_BURST_CONTROL -- requirements
Module: spi_burst_control

Interface
REQ-001 Parameter RX_DATA_WIDTH, default 10: width of RX word; legal 9..14.
REQ-002 Parameter MAX_BURST, default 16: maximum RX words per burst command; legal 1..255.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 spi_cs  input  1  chip select, high = deselected; aborts any command.
REQ-006 spi_rx_data  input  8  received SPI byte, valid with spi_rx_strobe.
REQ-007 spi_rx_strobe  input  1  one-cycle pulse per received byte.
REQ-008 spi_tx_data  output  8  byte to shift out next.
REQ-009 spi_tx_strobe  output  1  one-cycle pulse loading spi_tx_data.
REQ-010 rx_reset  output  1  one-cycle pulse resetting the receiver.
REQ-011 rx_active, rx_error, rx_empty  input  1 each  receiver status.
REQ-012 rx_data  input  RX_DATA_WIDTH  head word of RX FIFO.
REQ-013 rx_read_strobe  output  1  one-cycle pulse dequeuing the head word.

Function
REQ-014 All outputs SHALL be registered; strobes high for exactly one cycle.
REQ-015 Command = spi_rx_data[3:0] of the first byte strobed in IDLE; unknown codes SHALL be ignored, staying in IDLE.
REQ-016 Code 0x1 (STATUS): SHALL assert spi_tx_strobe with data {rx_active, rx_error, rx_empty, 5'b0} the cycle after the command strobe, then enter DONE.
REQ-017 Code 0x2 (RX_RESET): SHALL pulse rx_reset the cycle after the command strobe, then enter DONE.
REQ-018 Code 0x5 (RX_BURST): SHALL enter RX_COUNT; next strobed byte N sets burst length; N=0 or N>MAX_BURST SHALL clamp to MAX_BURST.
REQ-019 States: IDLE, STATUS, RESET_PULSE, RX_COUNT, RX_SAMPLE, RX_HIGH, RX_LOW_WAIT, RX_NEXT_WAIT, DONE.
REQ-020 RX_SAMPLE SHALL capture word {rx_error, rx_empty, zero pad, rx_data} (16 bits) one cycle after count byte or after RX_NEXT_WAIT strobe.
REQ-021 RX_HIGH SHALL pulse spi_tx_strobe with word[15:8] the cycle after capture.
REQ-022 RX_LOW_WAIT: on spi_rx_strobe SHALL pulse spi_tx_strobe with word[7:0]; same cycle pulse rx_reset if captured error, else rx_read_strobe if captured not-empty, else neither.
REQ-023 Remaining-word counter (8 bits) SHALL decrement on each low-byte send; at zero, or if the captured word had error or empty set, SHALL enter DONE; otherwise RX_NEXT_WAIT.
REQ-024 RX_NEXT_WAIT: on spi_rx_strobe SHALL go to RX_SAMPLE.
REQ-025 DONE SHALL ignore all strobes and issue no outputs until spi_cs high.
REQ-026 spi_cs high SHALL force IDLE next cycle, overriding any transition; strobes computed that same cycle SHALL still be issued.
REQ-027 spi_tx_data SHALL hold its last value when not strobed.

Reset
REQ-028 reset SHALL force IDLE, spi_tx_data=0, all strobes/pulses=0, captured word=0, counter=0; takes priority over spi_cs and mid-burst state; no pending dequeue SHALL survive.

Structure
REQ-029 Command codes, state encoding and status-byte bit positions SHALL live in shared package coax_pkg.
REQ-030 Single module; no sub-modules; parameter legality checked by elaboration-time assertion.

Verification
REQ-031 STATUS: rx_active=1, rx_error=0, rx_empty=1, send 0x01 -> one tx strobe, data 0xA0.
REQ-032 Burst N=2, FIFO words 0x155,0x2AA -> tx bytes 0x01,0x55,0x02,0xAA; two rx_read_strobe; DONE.
REQ-033 Burst N=4, FIFO empty after one word 0x003 -> bytes 0x00,0x03,0x40,0x00; one rx_read_strobe; DONE after 2nd word.
REQ-034 Burst N=3, rx_error=1 on first capture -> high byte has bit7 set, one rx_reset with low byte, no rx_read_strobe, DONE.
REQ-035 Burst N=0, MAX_BURST=16, 20 words available -> exactly 16 words sent, 16 dequeues.
REQ-036 spi_cs high in RX_LOW_WAIT, then reset mid-burst -> IDLE, no further strobes; new 0x01 command answered normally.
